// File: rtl/sram_pattern_tester_if.sv
// SRAM control bus between the pattern tester (master) and the memory (slave).
// Bus protocol: there is no valid/ready pair. A cycle with ce_n=0 is an access.
// we_n=0 with ce_n=0 is a write of the data lines at addr_bus, sampled by the
// memory on the rising edge. oe_n=0 with ce_n=0 asks the memory to drive the
// data lines. The master never asserts we_n and oe_n together.
// The bidirectional data lines are a plain inout port on the tester.
interface sram_pattern_tester_if #(
  parameter int ADDR_BITS = 10
);
  logic [ADDR_BITS-1:0] addr_bus;
  logic                 we_n;
  logic                 oe_n;
  logic                 ce_n;

  modport master (output addr_bus, output we_n, output oe_n, output ce_n);
  modport slave  (input  addr_bus, input  we_n, input  oe_n, input  ce_n);
endinterface

// File: rtl/sram_pattern_tester.sv
// SRAM pattern tester: writes one data pattern over the whole address space,
// reads it back and compares. Repeats for each enabled pattern, then stops,
// or loops forever when LOOP=1. Records the first failing cell.
module sram_pattern_tester #(
  parameter int         ADDR_BITS    = 10,
  parameter int         DATA_BITS    = 8,
  parameter int         READ_WAIT    = 2,
  parameter logic [3:0] PATTERN_MASK = 4'b1111,
  parameter bit         LOOP         = 1'b0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  sram_pattern_tester_if.master bus,
  inout  wire  [DATA_BITS-1:0] data_bus,
  output logic                 test_done,
  output logic                 test_pass,
  output logic                 rw,
  output logic [ADDR_BITS-1:0] addr,
  output logic [DATA_BITS-1:0] data_write,
  output logic [DATA_BITS-1:0] data_read,
  output logic [1:0]           pattern,
  output logic [15:0]          error_count,
  output logic [7:0]           pass_count,
  output logic [ADDR_BITS-1:0] fail_addr,
  output logic [DATA_BITS-1:0] fail_expected,
  output logic [DATA_BITS-1:0] fail_actual,
  output logic [2:0]           fsm_state
);

  typedef enum logic [2:0] {
    S_IDLE, S_WRITE, S_WRITE_HOLD, S_READ, S_NEXT, S_DONE
  } state_t;

  localparam logic [ADDR_BITS-1:0] LAST_ADDR = '1;
  localparam logic [3:0]           LAST_WAIT = 4'(READ_WAIT - 1);

  state_t     state, state_nx;
  logic [3:0] wait_cnt;
  logic       read_last;
  logic       drive_en;
  logic       ce_n, we_n, oe_n;
  logic [1:0] first_pat, next_pat;
  logic       has_next;

  // Data pattern p for address a.
  function automatic logic [DATA_BITS-1:0] pat_data(input logic [1:0] p,
                                                    input logic [ADDR_BITS-1:0] a);
    logic [ADDR_BITS+DATA_BITS-1:0] ext;
    logic [DATA_BITS-1:0]           d;
    ext = {{DATA_BITS{1'b0}}, a};
    d   = '0;
    case (p)
      2'd0:    d = ext[DATA_BITS-1:0];
      2'd1:    d = ~ext[DATA_BITS-1:0];
      2'd2:    for (int b = 0; b < DATA_BITS; b++) d[b] = ((b % 2) == 0) ^ a[0];
      default: for (int b = 0; b < DATA_BITS; b++) d[b] = (b == (int'(a) % DATA_BITS));
    endcase
    return d;
  endfunction

  // Lowest enabled pattern, and the next enabled pattern above the current one.
  always_comb begin
    first_pat = 2'd0;
    next_pat  = pattern;
    has_next  = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      if (PATTERN_MASK[i]) first_pat = 2'(i);
      if (PATTERN_MASK[i] && (i > int'(pattern))) begin
        next_pat = 2'(i);
        has_next = 1'b1;
      end
    end
  end

  assign read_last  = (wait_cnt == LAST_WAIT);
  assign data_write = pat_data(pattern, addr);

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:       state_nx = (PATTERN_MASK == 4'b0000) ? S_DONE : S_WRITE;
      S_WRITE:      state_nx = S_WRITE_HOLD;
      S_WRITE_HOLD: state_nx = (addr == LAST_ADDR) ? S_READ : S_WRITE;
      S_READ:       if (read_last && (addr == LAST_ADDR)) state_nx = S_NEXT;
      S_NEXT:       state_nx = has_next ? S_WRITE : (LOOP ? S_IDLE : S_DONE);
      S_DONE:       state_nx = S_DONE;
      default:      state_nx = S_IDLE;
    endcase
  end

  // Bus strobes decoded from the state; data is driven only while writing.
  always_comb begin
    ce_n     = 1'b1;
    we_n     = 1'b1;
    oe_n     = 1'b1;
    rw       = 1'b0;
    drive_en = 1'b0;
    case (state)
      S_WRITE:      begin ce_n = 1'b0; we_n = 1'b0; drive_en = 1'b1; end
      S_WRITE_HOLD: begin ce_n = 1'b0; drive_en = 1'b1; end
      S_READ:       begin ce_n = 1'b0; oe_n = 1'b0; rw = 1'b1; end
      default:      ;
    endcase
  end

  assign bus.ce_n     = ce_n;
  assign bus.we_n     = we_n;
  assign bus.oe_n     = oe_n;
  assign bus.addr_bus = addr;
  assign data_bus     = drive_en ? data_write : {DATA_BITS{1'bz}};
  assign fsm_state    = state;

  // Address, wait counter, read-back compare and status registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      addr          <= '0;
      wait_cnt      <= '0;
      pattern       <= 2'd0;
      data_read     <= '0;
      test_done     <= 1'b0;
      test_pass     <= 1'b1;
      error_count   <= '0;
      pass_count    <= '0;
      fail_addr     <= '0;
      fail_expected <= '0;
      fail_actual   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          pattern  <= first_pat;
          addr     <= '0;
          wait_cnt <= '0;
          if (PATTERN_MASK == 4'b0000) test_done <= 1'b1;
        end
        S_WRITE_HOLD: addr <= addr + 1'b1;
        S_READ: begin
          if (read_last) begin
            wait_cnt  <= '0;
            addr      <= addr + 1'b1;
            data_read <= data_bus;
            if (data_bus != data_write) begin
              if (error_count != 16'hFFFF) error_count <= error_count + 1'b1;
              // test_pass still high means this is the first mismatch.
              if (test_pass) begin
                fail_addr     <= addr;
                fail_expected <= data_write;
                fail_actual   <= data_bus;
              end
              test_pass <= 1'b0;
            end
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_NEXT: begin
          if (has_next) begin
            pattern <= next_pat;
          end else begin
            test_done <= 1'b1;
            if (LOOP) pass_count <= pass_count + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/sram_pattern_tester.md
SRAM_PATTERN_TESTER -- requirements
Module: sram_pattern_tester

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 10: SRAM address width.
REQ-002 SHALL have parameter DATA_BITS, default 8: SRAM data width.
REQ-003 SHALL have parameter READ_WAIT, default 2: cycles oe_n is held low per read (legal range 1..15).
REQ-004 SHALL have parameter PATTERN_MASK, default 4'b1111: bit i enables pattern i.
REQ-005 SHALL have parameter LOOP, default 0: 1 = repeat the sweep forever.
REQ-006 SHALL have port clk, input, 1: the single clock; all state changes on the rising edge.
REQ-007 SHALL have port reset_n, input, 1: synchronous, active-low reset.
REQ-008 SHALL have ports test_done (output, 1) and test_pass (output, 1).
REQ-009 SHALL have ports addr_bus (output, ADDR_BITS), data_bus (inout, DATA_BITS), and we_n/oe_n/ce_n (output, 1 each, active-low).
REQ-010 SHALL have debug ports rw (output, 1; 1 = read), addr (output, ADDR_BITS), data_write (output, DATA_BITS) and data_read (output, DATA_BITS; last sampled bus value).
REQ-011 SHALL have status ports pattern (output, 2; current pattern), error_count (output, 16) and pass_count (output, 8).
REQ-012 SHALL have first-failure ports fail_addr (output, ADDR_BITS), fail_expected (output, DATA_BITS) and fail_actual (output, DATA_BITS).

Function
REQ-013 SHALL use these patterns: 0 = address (zero-extended or truncated to DATA_BITS); 1 = ~address; 2 = checkerboard (0x55.. at even addresses, 0xAA.. at odd); 3 = walking one, with bit (addr mod DATA_BITS) set.
REQ-014 SHALL implement states IDLE, WRITE, WRITE_HOLD, READ, NEXT and DONE.
REQ-015 SHALL spend exactly 1 cycle in IDLE after reset release, then go to WRITE at address 0 of the lowest enabled pattern; PATTERN_MASK=0 SHALL go IDLE->DONE with test_pass=1.
REQ-016 SHALL, in WRITE (1 cycle), drive ce_n=0, we_n=0, oe_n=1, addr_bus=addr and data_bus=pattern data.
REQ-017 SHALL, in WRITE_HOLD (1 cycle), hold we_n=1 with addr and data still driven; the address then increments, and after the last address (2^ADDR_BITS-1, wrapping to 0) the block goes to READ.
REQ-018 SHALL, in READ, drive ce_n=0, oe_n=0, we_n=1 and leave data_bus high-Z for READ_WAIT cycles, then sample data_bus on the rising edge that ends the last cycle.
REQ-019 SHALL update data_read with the sample and compare it against the expected data on that same edge.
REQ-020 SHALL, after reading the last address, go to NEXT (1 cycle, ce_n=1), then to WRITE of the next enabled pattern, or to DONE after the highest enabled pattern.
REQ-021 SHALL take 1 + P*(2^ADDR_BITS*(2+READ_WAIT)+1) cycles per sweep, where P = number of enabled patterns.
REQ-022 SHALL drive data_bus only in WRITE and WRITE_HOLD, so oe_n=0 and bus drive never coincide.
REQ-023 SHALL, in DONE, hold test_done=1 and ce_n=we_n=oe_n=1.
REQ-024 SHALL, with LOOP=1, increment pass_count (wrapping at 255) and restart at the first enabled pattern instead of stopping; test_done SHALL rise at the end of the first sweep and stay 1.
REQ-025 SHALL, on a mismatch, saturate-increment error_count at 0xFFFF and clear test_pass (sticky).
REQ-026 SHALL load fail_addr/fail_expected/fail_actual on the first mismatch only and hold them thereafter.
REQ-027 SHALL hold rw=1 in READ and rw=0 otherwise; addr SHALL mirror addr_bus and data_write SHALL mirror the pattern data.

Reset
REQ-028 SHALL, while reset_n=0 at a rising edge, set state=IDLE, test_done=0, test_pass=1, ce_n=we_n=oe_n=1, data_bus high-Z, and rw, addr, data_write, data_read, pattern, error_count, pass_count and fail_* all 0.
REQ-029 SHALL, on reset mid-sweep, abort the sweep, take reset values on the next edge and restart from IDLE with no retained error state.

Verification (sram_model, ADDR_BITS=4, DATA_BITS=8, READ_WAIT=2)
REQ-030 SHALL cover: clean run with all patterns -> test_done first 1 at cycle 261 after reset release, test_pass=1, error_count=0.
REQ-031 SHALL cover: cell 4 bit 0 forced to 1 -> fail_addr=4, fail_expected=0x04, fail_actual=0x05, error_count=2, test_pass=0, test_done=1.
REQ-032 SHALL cover: PATTERN_MASK=4'b0100 -> pattern=2 throughout, test_done at cycle 66; PATTERN_MASK=0 -> test_done at cycle 1 with test_pass=1.
REQ-033 SHALL cover: reset_n pulsed low at cycle 100 -> all outputs at reset values next edge, then a full clean run completing 261 cycles after release.
REQ-034 SHALL cover: every cycle of any run -> data_bus high-Z whenever oe_n=0, and we_n=0 only while ce_n=0.
REQ-035 SHALL cover: LOOP=1 -> pass_count=2 after 522 cycles, test_done stays 1, error_count=0.
